// File: rtl/cache_state_array.sv
// Valid/dirty state array for a set-associative cache, with a sequential flush
// engine that walks every (set, way) and hands dirty lines to the write-back path.

module cache_state_set #(
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            wr_en,
    input  logic [WAYS-1:0] wr_mask,
    input  logic            wr_valid,
    input  logic            wr_dirty,
    input  logic [WAYS-1:0] clr_mask,
    output logic [WAYS-1:0] valid,
    output logic [WAYS-1:0] dirty
);
    // A line is never held dirty while invalid.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (clr_mask[w]) begin
                    valid[w] <= 1'b0;
                    dirty[w] <= 1'b0;
                end else if (wr_en && wr_mask[w]) begin
                    valid[w] <= wr_valid;
                    dirty[w] <= wr_valid & wr_dirty;
                end
            end
        end
    end
endmodule

module cache_state_array #(
    parameter  int SETS  = 128,
    parameter  int WAYS  = 2,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  rd_valid,
    output logic [WAYS-1:0]  rd_dirty,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WAYS-1:0]  wr_way,
    input  logic             wr_valid,
    input  logic             wr_dirty,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_req,
    output logic [IDX_W-1:0] wb_idx,
    output logic [WAY_W-1:0] wb_way,
    input  logic             wb_ack
);
    typedef enum logic [1:0] {IDLE, SCAN, WB_WAIT, DONE} state_t;

    state_t                      state, state_nx;
    logic [IDX_W-1:0]            ptr_set;
    logic [WAY_W-1:0]            ptr_way;
    logic [SETS-1:0][WAYS-1:0]   vld_q, drt_q;
    logic [WAYS-1:0]             clr_mask;
    logic                        cur_v, cur_d, last_ent, adv, idle;

    assign idle     = (state == IDLE);
    assign cur_v    = vld_q[ptr_set][ptr_way];
    assign cur_d    = drt_q[ptr_set][ptr_way];
    assign last_ent = (ptr_set == IDX_W'(SETS-1)) && (ptr_way == WAY_W'(WAYS-1));
    assign clr_mask = adv ? (WAYS'(1) << ptr_way) : '0;

    for (genvar s = 0; s < SETS; s++) begin : g_set
        cache_state_set #(.WAYS(WAYS)) u_set (
            .clk      (clk),
            .nReset   (nReset),
            .wr_en    (idle && wr_en && (wr_idx == IDX_W'(s))),
            .wr_mask  (wr_way),
            .wr_valid (wr_valid),
            .wr_dirty (wr_dirty),
            .clr_mask ((ptr_set == IDX_W'(s)) ? clr_mask : '0),
            .valid    (vld_q[s]),
            .dirty    (drt_q[s])
        );
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    // adv clears the entry under the pointer and steps to the next one.
    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        case (state)
            IDLE:    if (flush_req) state_nx = SCAN;
            SCAN: begin
                if (cur_v && cur_d) begin
                    state_nx = WB_WAIT;
                end else begin
                    adv      = 1'b1;
                    state_nx = last_ent ? DONE : SCAN;
                end
            end
            WB_WAIT: begin
                if (wb_ack) begin
                    adv      = 1'b1;
                    state_nx = last_ent ? DONE : SCAN;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ptr_set <= '0;
            ptr_way <= '0;
        end else if (idle && flush_req) begin
            ptr_set <= '0;
            ptr_way <= '0;
        end else if (adv) begin
            if (ptr_way == WAY_W'(WAYS-1)) begin
                ptr_way <= '0;
                ptr_set <= ptr_set + IDX_W'(1);
            end else begin
                ptr_way <= ptr_way + WAY_W'(1);
            end
        end
    end

    // Reads sample pre-write contents; outputs hold while a flush runs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_valid <= '0;
            rd_dirty <= '0;
        end else if (idle && rd_en) begin
            rd_valid <= vld_q[rd_idx];
            rd_dirty <= drt_q[rd_idx];
        end
    end

    assign flush_busy = (state == SCAN) || (state == WB_WAIT);
    assign flush_done = (state == DONE);
    assign wb_req     = (state == WB_WAIT);
    assign wb_idx     = ptr_set;
    assign wb_way     = ptr_way;
endmodule

// File: tb/tb_cache_state_array.sv
// Randomized and directed bench for cache_state_array against an entry-counter model.

module tb_cache_state_array;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int IDX_W = 3;
    localparam int WAY_W = 1;

    logic             clk = 1'b0, nReset = 1'b0;
    logic             rd_en = 1'b0, wr_en = 1'b0, wr_valid = 1'b0, wr_dirty = 1'b0;
    logic             flush_req = 1'b0, wb_ack = 1'b0;
    logic [IDX_W-1:0] rd_idx = '0, wr_idx = '0;
    logic [WAYS-1:0]  wr_way = '0;
    logic [WAYS-1:0]  rd_valid, rd_dirty;
    logic             flush_busy, flush_done, wb_req;
    logic [IDX_W-1:0] wb_idx;
    logic [WAY_W-1:0] wb_way;

    cache_state_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .nReset(nReset), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_dirty(rd_dirty), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_way(wr_way), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_req(wb_req), .wb_idx(wb_idx), .wb_way(wb_way), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: mode 0 idle, 1 flushing, 2 done pulse; k = set*WAYS+way being visited,
    // w = waiting for the write-back of entry k.
    typedef struct packed {
        logic [SETS-1:0][WAYS-1:0] v;
        logic [SETS-1:0][WAYS-1:0] d;
        logic [WAYS-1:0]           rv;
        logic [WAYS-1:0]           rd;
        logic [1:0]                mode;
        logic [31:0]               k;
        logic                      w;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t mi);
        model_t r;
        int s, w;
        r = mi;
        if (r.mode == 2'd0) begin
            if (rd_en) begin
                r.rv = r.v[rd_idx];
                r.rd = r.d[rd_idx];
            end
            if (wr_en)
                for (int i = 0; i < WAYS; i++)
                    if (wr_way[i]) begin
                        r.v[wr_idx][i] = wr_valid;
                        r.d[wr_idx][i] = wr_valid & wr_dirty;
                    end
            if (flush_req) begin
                r.mode = 2'd1;
                r.k    = 0;
                r.w    = 1'b0;
            end
        end else if (r.mode == 2'd1) begin
            s = int'(r.k) / WAYS;
            w = int'(r.k) % WAYS;
            if (!r.w && r.v[s][w] && r.d[s][w]) begin
                r.w = 1'b1;
            end else if (!r.w || wb_ack) begin
                r.v[s][w] = 1'b0;
                r.d[s][w] = 1'b0;
                r.w       = 1'b0;
                r.k       = r.k + 1;
                if (r.k == SETS*WAYS) r.mode = 2'd2;
            end
        end else begin
            r.mode = 2'd0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge nReset) begin
        if (!nReset) m <= '0;
        else         m <= step(m);
    end

    always @(negedge clk) begin
        if (nReset) begin
            chk("rd_valid", rd_valid, m.rv);
            chk("rd_dirty", rd_dirty, m.rd);
            chk("flush_busy", flush_busy, m.mode == 2'd1);
            chk("flush_done", flush_done, m.mode == 2'd2);
            chk("wb_req", wb_req, (m.mode == 2'd1) && m.w);
            if ((m.mode == 2'd1) && m.w) begin
                chk("wb_idx", wb_idx, m.k / WAYS);
                chk("wb_way", wb_way, m.k % WAYS);
            end
        end
    end

    task automatic write(input int idx, input logic [1:0] way, input logic v, input logic d);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_way = way; wr_valid = v; wr_dirty = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read(input int idx, output logic [1:0] v, output logic [1:0] d);
        @(negedge clk);
        rd_en = 1'b1; rd_idx = IDX_W'(idx);
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_valid; d = rd_dirty;
    endtask

    task automatic check_empty(input string nm);
        logic [1:0] v, d;
        for (int s = 0; s < SETS; s++) begin
            read(s, v, d);
            chk(nm, {v, d}, 4'b0000);
        end
    endtask

    logic [3:0] wb_seen[$];

    task automatic run_flush(input int ack_dly, output int busy, output int dn);
        int cnt;
        busy = 0; dn = 0; cnt = 0;
        wb_seen.delete();
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        for (int c = 0; c < 200 && dn == 0; c++) begin
            if (c > 0) @(negedge clk);
            wb_ack = 1'b0;
            if (flush_busy) busy++;
            if (flush_done) dn++;
            if (wb_req) begin
                cnt++;
                if (cnt == 1) wb_seen.push_back({wb_idx, wb_way});
                if (cnt == ack_dly) begin
                    wb_ack = 1'b1;
                    cnt    = 0;
                end
            end
        end
        if (dn == 0) chk("flush_timeout", 0, 1);
        @(negedge clk);
        if (flush_done) dn++;
    endtask

    initial begin
        logic [1:0] v, d;
        int busy, dn, seen;

        repeat (3) @(negedge clk);
        nReset = 1'b1;

        // read after reset returns an empty set
        read(5, v, d);
        chk("reset_read", {v, d}, 4'b0000);

        // write and read of set 3 in the same cycle sees the old contents
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 3'd3; wr_way = 2'b10; wr_valid = 1'b1; wr_dirty = 1'b1;
        rd_en = 1'b1; rd_idx = 3'd3;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rbw_valid", rd_valid, 2'b00);
        chk("rbw_dirty", rd_dirty, 2'b00);
        read(3, v, d);
        chk("rd3_valid", v, 2'b10);
        chk("rd3_dirty", d, 2'b10);
        chk("model_rv", m.rv, 2'b10);

        // invalid write drops the dirty bit
        write(2, 2'b11, 1'b0, 1'b1);
        read(2, v, d);
        chk("inv_write", {v, d}, 4'b0000);

        // zero way mask is a no-op
        write(3, 2'b00, 1'b0, 1'b0);
        read(3, v, d);
        chk("mask0", {v, d}, 4'b1010);

        // clean-only flush
        write(3, 2'b11, 1'b0, 1'b0);
        write(0, 2'b01, 1'b1, 1'b0);
        write(7, 2'b11, 1'b1, 1'b0);
        run_flush(3, busy, dn);
        chk("clean_busy", busy, 16);
        chk("clean_done", dn, 1);
        chk("clean_wb", wb_seen.size(), 0);
        chk("model_empty", m.v, 0);
        check_empty("clean_empty");

        // two dirty lines, write-back ack after 3 cycles each
        write(1, 2'b01, 1'b1, 1'b1);
        write(6, 2'b10, 1'b1, 1'b1);
        run_flush(3, busy, dn);
        chk("dirty_busy", busy, 22);
        chk("dirty_done", dn, 1);
        seen = wb_seen.size();
        chk("dirty_wb_cnt", seen, 2);
        if (seen >= 2) begin
            chk("wb_first", wb_seen[0], {3'd1, 1'b0});
            chk("wb_second", wb_seen[1], {3'd6, 1'b1});
        end
        check_empty("dirty_empty");

        // reset during write-back wait aborts the flush
        write(4, 2'b01, 1'b1, 1'b1);
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        for (int c = 0; c < 40 && !wb_req; c++) @(negedge clk);
        chk("abort_wb_seen", wb_req, 1'b1);
        #2 nReset = 1'b0;
        #1;
        chk("abort_wb_req", wb_req, 1'b0);
        chk("abort_busy", flush_busy, 1'b0);
        chk("abort_done", flush_done, 1'b0);
        @(negedge clk); nReset = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (flush_done) dn++;
        end
        chk("abort_no_done", dn, 0);
        read(4, v, d);
        chk("abort_cleared", {v, d}, 4'b0000);
        run_flush(1, busy, dn);
        chk("reflush_busy", busy, 16);
        chk("reflush_done", dn, 1);

        // random traffic, model compared every cycle
        repeat (800) begin
            @(negedge clk);
            rd_en     = 1'($urandom_range(0, 1));
            rd_idx    = IDX_W'($urandom_range(0, SETS-1));
            wr_en     = 1'($urandom_range(0, 1));
            wr_idx    = IDX_W'($urandom_range(0, SETS-1));
            wr_way    = WAYS'($urandom_range(0, 3));
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_dirty  = 1'($urandom_range(0, 1));
            flush_req = ($urandom_range(0, 99) < 4);
            wb_ack    = ($urandom_range(0, 99) < 40);
        end
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0; wb_ack = 1'b1;
        for (int c = 0; c < 100 && (flush_busy || flush_done); c++) @(negedge clk);
        chk("final_idle", flush_busy, 1'b0);
        wb_ack = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cache_state_array.md
CACHE_STATE_ARRAY -- requirements
Module: cache_state_array

Interface
REQ-001 The block SHALL have parameter SETS, default 128, meaning number of cache sets (power of two, >=2).
REQ-002 The block SHALL have parameter WAYS, default 2, meaning associativity (power of two, >=1).
REQ-003 The block SHALL have derived parameters IDX_W = clog2(SETS) and WAY_W = max(1, clog2(WAYS)).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 nReset  input  1  reset, asynchronous, active-low.
REQ-006 rd_en  input  1  read request for set rd_idx.
REQ-007 rd_idx  input  IDX_W  set index to read.
REQ-008 rd_valid  output  WAYS  registered valid bits of the set read; bit w = way w.
REQ-009 rd_dirty  output  WAYS  registered dirty bits of the set read.
REQ-010 wr_en  input  1  state write request.
REQ-011 wr_idx  input  IDX_W  set index to write.
REQ-012 wr_way  input  WAYS  way select mask; multiple bits allowed.
REQ-013 wr_valid  input  1  valid value to store.
REQ-014 wr_dirty  input  1  dirty value to store.
REQ-015 flush_req  input  1  start a flush of the whole array.
REQ-016 flush_busy  output  1  flush in progress.
REQ-017 flush_done  output  1  one-cycle pulse at flush completion.
REQ-018 wb_req  output  1  write-back request for a dirty line found during flush.
REQ-019 wb_idx  output  IDX_W  set of line to write back.
REQ-020 wb_way  output  WAY_W  way of line to write back.
REQ-021 wb_ack  input  1  write-back accepted by the data path.

Function
REQ-022 Storage SHALL be SETS x WAYS valid bits and SETS x WAYS dirty bits.
REQ-023 Read latency SHALL be one cycle: rd_en high at edge N loads rd_valid/rd_dirty with set rd_idx, visible after edge N; with rd_en low the outputs SHALL hold.
REQ-024 Simultaneous read and write of the same set SHALL return the pre-write contents (read-before-write).
REQ-025 A write SHALL set valid=wr_valid and dirty=wr_dirty & wr_valid in every way with wr_way bit set at set wr_idx; a line is never stored dirty and invalid.
REQ-026 wr_en with wr_way = 0 SHALL change nothing.
REQ-027 The flush FSM SHALL have states IDLE, SCAN, WB_WAIT, DONE.
REQ-028 IDLE -> SCAN on flush_req; scan pointer (set, way) loads (0, 0).
REQ-029 In SCAN, one entry per cycle: if valid & dirty, go WB_WAIT; otherwise clear its valid bit and advance.
REQ-030 In WB_WAIT, wb_req SHALL be high with wb_idx/wb_way = scan pointer, stable until wb_ack; on the wb_ack cycle the entry's valid and dirty bits clear and the pointer advances back to SCAN.
REQ-031 Advance SHALL increment way, wrapping to 0 and incrementing set; advancing past (SETS-1, WAYS-1) SHALL enter DONE.
REQ-032 DONE SHALL assert flush_done for exactly one cycle and return to IDLE.
REQ-033 flush_busy SHALL be high exactly in SCAN and WB_WAIT.
REQ-034 A flush of an array with no dirty lines SHALL take SETS*WAYS cycles of flush_busy followed by one flush_done cycle.
REQ-035 While not IDLE, wr_en and rd_en SHALL be ignored and rd_valid/rd_dirty SHALL hold.
REQ-036 flush_req while not IDLE SHALL be ignored; flush_req on the flush_done cycle SHALL also be ignored.
REQ-037 wb_ack outside WB_WAIT SHALL be ignored.

Reset
REQ-038 nReset low SHALL asynchronously clear all valid and dirty bits, rd_valid, rd_dirty, wb_req, wb_idx, wb_way, flush_busy, flush_done, and force IDLE.
REQ-039 Reset asserted mid-flush SHALL abort the flush with no flush_done pulse.

Verification (SETS=8, WAYS=2)
REQ-040 Reset, rd_en idx 5 -> rd_valid=00, rd_dirty=00 next cycle.
REQ-041 Write idx 3 wr_way=10 valid=1 dirty=1, same cycle read idx 3 -> 00/00; read next cycle -> rd_valid=10, rd_dirty=10.
REQ-042 Write idx 2 wr_way=11 valid=0 dirty=1 -> read gives 00/00.
REQ-043 Lines valid clean at idx 0,7; flush_req -> flush_busy high 16 cycles, flush_done one pulse, all entries invalid, wb_req never high.
REQ-044 Dirty lines (1,0) and (6,1); flush, wb_ack delayed 3 cycles each -> wb_req with wb_idx=1 wb_way=0, then 6/1, held until ack; flush_done after 16+2*3 busy cycles total; array empty.
REQ-045 nReset pulse during WB_WAIT -> wb_req low, IDLE, no flush_done, array cleared; new flush_req then completes normally.
